// File: rtl/dcache_responder.sv
// Blocking direct-mapped write-back, write-allocate D-cache with single-beat 256-bit line refill/writeback.
// Optional event counters are built in when DCACHE_PERF_CNT_EN is defined; otherwise perf_* are tied to 0.
module dcache_responder #(
  parameter int NUM_SETS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [31:0]  ufp_addr,
  input  logic [3:0]   ufp_rmask,
  input  logic [3:0]   ufp_wmask,
  input  logic [31:0]  ufp_wdata,
  output logic [31:0]  ufp_rdata,
  output logic         ufp_resp,
  output logic [31:0]  dfp_addr,
  output logic         dfp_read,
  output logic         dfp_write,
  output logic [255:0] dfp_wdata,
  input  logic [255:0] dfp_rdata,
  input  logic         dfp_resp,
  output logic [31:0]  perf_hits,
  output logic [31:0]  perf_misses,
  output logic [31:0]  perf_writebacks
);

  localparam int SET_W = $clog2(NUM_SETS);
  localparam int TAG_W = 27 - SET_W;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_nxt;

  logic [255:0]     data_arr [NUM_SETS];
  logic [TAG_W-1:0] tag_arr  [NUM_SETS];
  logic [NUM_SETS-1:0] valid, dirty;

  logic [31:2]      req_addr;
  logic [3:0]       req_wmask;
  logic [31:0]      req_wdata;
  logic             req_write;
  logic             drop;
  logic             refilled;

  logic [TAG_W-1:0] req_tag;
  logic [SET_W-1:0] req_set;
  logic [2:0]       req_word;
  logic [255:0]     cur_line;
  logic [31:0]      cur_word, merged_word;
  logic             hit, accept, do_merge;
  logic             unused_bits;

  assign unused_bits = ^ufp_addr[1:0];

  assign req_tag  = req_addr[31:5+SET_W];
  assign req_set  = req_addr[4+SET_W:5];
  assign req_word = req_addr[4:2];
  assign cur_line = data_arr[req_set];
  assign cur_word = cur_line[{req_word, 5'b0} +: 32];
  assign hit      = valid[req_set] && (tag_arr[req_set] == req_tag);
  assign accept   = (state == IDLE) && ((ufp_rmask | ufp_wmask) != 4'b0) && !flush;

  always_comb begin
    merged_word = cur_word;
    for (int b = 0; b < 4; b++)
      if (req_wmask[b]) merged_word[8*b +: 8] = req_wdata[8*b +: 8];
  end

  always_comb begin
    state_nxt = state;
    ufp_resp  = 1'b0;
    ufp_rdata = '0;
    dfp_read  = 1'b0;
    dfp_write = 1'b0;
    dfp_addr  = '0;
    dfp_wdata = '0;
    do_merge  = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = COMPARE;
      COMPARE: begin
        // One settle cycle after a refill before the line is compared.
        if (refilled) begin
          state_nxt = COMPARE;
        end else if (hit) begin
          do_merge  = req_write;
          ufp_resp  = !(drop || flush);
          ufp_rdata = (req_write || drop || flush) ? 32'b0 : cur_word;
          state_nxt = IDLE;
        end else if (valid[req_set] && dirty[req_set]) begin
          state_nxt = WRITEBACK;
        end else begin
          state_nxt = ALLOCATE;
        end
      end
      WRITEBACK: begin
        dfp_write = 1'b1;
        dfp_addr  = {tag_arr[req_set], req_set, 5'b0};
        dfp_wdata = cur_line;
        if (dfp_resp) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        dfp_read = 1'b1;
        dfp_addr = {req_addr[31:5], 5'b0};
        if (dfp_resp) state_nxt = COMPARE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_wmask <= '0;
      req_wdata <= '0;
      req_write <= 1'b0;
      drop      <= 1'b0;
      refilled  <= 1'b0;
      valid     <= '0;
      dirty     <= '0;
    end else begin
      state    <= state_nxt;
      refilled <= (state == ALLOCATE) && dfp_resp;
      if (accept) begin
        req_addr  <= ufp_addr[31:2];
        req_wmask <= ufp_wmask;
        req_wdata <= ufp_wdata;
        req_write <= (ufp_wmask != 4'b0);
      end
      if (state_nxt == IDLE)
        drop <= 1'b0;
      else if (flush && state != IDLE)
        drop <= 1'b1;
      if (state == WRITEBACK && dfp_resp)
        dirty[req_set] <= 1'b0;
      if (state == ALLOCATE && dfp_resp) begin
        valid[req_set] <= 1'b1;
        dirty[req_set] <= 1'b0;
      end
      if (do_merge)
        dirty[req_set] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ALLOCATE && dfp_resp) begin
      data_arr[req_set] <= dfp_rdata;
      tag_arr[req_set]  <= req_tag;
    end else if (do_merge) begin
      data_arr[req_set][{req_word, 5'b0} +: 32] <= merged_word;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic        allocated;
  logic [31:0] hits_q, misses_q, wbs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      allocated <= 1'b0;
      hits_q    <= '0;
      misses_q  <= '0;
      wbs_q     <= '0;
    end else begin
      if (accept)
        allocated <= 1'b0;
      else if (state == ALLOCATE)
        allocated <= 1'b1;
      if (state == COMPARE && !refilled && hit && !allocated && hits_q != 32'hFFFF_FFFF)
        hits_q <= hits_q + 32'd1;
      if (state == COMPARE && !refilled && !hit && misses_q != 32'hFFFF_FFFF)
        misses_q <= misses_q + 32'd1;
      if (state == WRITEBACK && dfp_resp && wbs_q != 32'hFFFF_FFFF)
        wbs_q <= wbs_q + 32'd1;
    end
  end

  assign perf_hits       = hits_q;
  assign perf_misses     = misses_q;
  assign perf_writebacks = wbs_q;
`else
  assign perf_hits       = '0;
  assign perf_misses     = '0;
  assign perf_writebacks = '0;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Randomized and directed bench for dcache_responder against an architectural memory + tag-state reference model.
module tb_dcache_responder;

  localparam int NUM_SETS = 16;

  logic         clk, rst_n, flush;
  logic [31:0]  ufp_addr, ufp_wdata, ufp_rdata;
  logic [3:0]   ufp_rmask, ufp_wmask;
  logic         ufp_resp;
  logic [31:0]  dfp_addr;
  logic         dfp_read, dfp_write, dfp_resp;
  logic [255:0] dfp_wdata, dfp_rdata;
  logic [31:0]  perf_hits, perf_misses, perf_writebacks;

  dcache_responder #(.NUM_SETS(NUM_SETS)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_wmask(ufp_wmask), .ufp_wdata(ufp_wdata),
    .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_wdata(dfp_wdata),
    .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_writebacks(perf_writebacks)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  txn_t         log_q[$];
  logic [255:0] mem  [logic [26:0]];
  logic [255:0] arch [logic [26:0]];
  bit           mem_hold = 0;
  int           last_dfp_cyc = 0;
  int           proto_bad = 0;

  // Reference tag state: which line each set holds and whether it diverges from memory.
  bit           mvalid [NUM_SETS];
  bit           mdirty [NUM_SETS];
  logic [22:0]  mtag   [NUM_SETS];
  int           mh = 0, mm = 0, mw = 0;

  function automatic logic [255:0] init_line(input logic [26:0] la);
    logic [255:0] r;
    for (int i = 0; i < 8; i++)
      r[32*i +: 32] = (32'(la) * 32'h9E37_79B9) ^ (32'(i) << 28) ^ 32'h1357_9BDF;
    return r;
  endfunction

  function automatic logic [255:0] get_mem(input logic [26:0] la);
    return mem.exists(la) ? mem[la] : init_line(la);
  endfunction

  function automatic logic [255:0] get_arch(input logic [26:0] la);
    return arch.exists(la) ? arch[la] : init_line(la);
  endfunction

  // Memory side: random 0-3 cycle latency, logs every completed transaction.
  initial begin
    bit           pending = 0;
    int           dly = 0;
    logic [31:0]  p_addr;
    bit           p_wr;
    logic [255:0] p_data;
    dfp_resp = 1'b0;
    dfp_rdata = '0;
    forever begin
      @(negedge clk);
      dfp_resp = 1'b0;
      if (!rst_n || !(dfp_read || dfp_write)) begin
        pending = 0;
      end else begin
        if (dfp_read && dfp_write) proto_bad++;
        if (dfp_addr[4:0] != 5'b0) proto_bad++;
        if (!pending) begin
          pending = 1;
          dly = $urandom_range(0, 3);
          p_addr = dfp_addr; p_wr = dfp_write; p_data = dfp_wdata;
        end else if (dfp_addr !== p_addr || dfp_write !== p_wr || (p_wr && dfp_wdata !== p_data)) begin
          proto_bad++;
        end
        if (dly == 0 && !mem_hold) begin
          if (dfp_write) begin
            mem[dfp_addr[31:5]] = dfp_wdata;
            log_q.push_back('{1'b1, dfp_addr, dfp_wdata});
          end else begin
            dfp_rdata = get_mem(dfp_addr[31:5]);
            log_q.push_back('{1'b0, dfp_addr, dfp_rdata});
          end
          dfp_resp = 1'b1;
          last_dfp_cyc = cyc;
          pending = 0;
        end else if (dly > 0) begin
          dly--;
        end
      end
    end
  end

  task automatic model_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                           input logic [31:0] wd, output bit hit, output bit wb,
                           output logic [31:0] vaddr, output logic [255:0] vdata,
                           output logic [31:0] rd);
    int s = int'(a[8:5]);
    logic [255:0] line = get_arch(a[31:5]);
    hit   = mvalid[s] && mtag[s] == a[31:9];
    wb    = !hit && mvalid[s] && mdirty[s];
    vaddr = {mtag[s], a[8:5], 5'b0};
    vdata = get_arch(vaddr[31:5]);
    rd    = (wm != 4'b0) ? 32'b0 : line[32*a[4:2] +: 32];
    if (rm == 4'b0 && wm == 4'b0) rd = 32'b0;
    if (hit) mh++;
    else begin
      mm++;
      if (wb) mw++;
      mvalid[s] = 1; mtag[s] = a[31:9]; mdirty[s] = 0;
    end
    if (wm != 4'b0) begin
      for (int b = 0; b < 4; b++)
        if (wm[b]) line[32*a[4:2] + 8*b +: 8] = wd[8*b +: 8];
      arch[a[31:5]] = line;
      mdirty[s] = 1;
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, input bit fl, output int nresp,
                        output logic [31:0] rdata, output int lat, output int rafter);
    int t0, fcyc;
    bit flushed = 0;
    log_q.delete();
    @(negedge clk);
    ufp_addr = a; ufp_rmask = rm; ufp_wmask = wm; ufp_wdata = wd;
    t0 = cyc; nresp = 0; lat = -1; rafter = -1; rdata = 'x; fcyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      flush = 1'b0;
      if (fl && !flushed && dfp_read) begin
        flush = 1'b1; flushed = 1; fcyc = cyc;
        ufp_rmask = 4'b0; ufp_wmask = 4'b0;
      end
      if (ufp_resp) begin
        nresp++;
        if (lat < 0) begin
          lat = cyc - t0; rdata = ufp_rdata; rafter = cyc - last_dfp_cyc;
          ufp_rmask = 4'b0; ufp_wmask = 4'b0;
        end
      end
      if (lat >= 0 && cyc - t0 >= lat + 3) break;
      if (flushed && cyc - fcyc >= 12 && !dfp_read && !dfp_write) break;
    end
    flush = 1'b0; ufp_rmask = 4'b0; ufp_wmask = 4'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (ufp_resp !== 1'b0 || ufp_rdata !== 32'b0) begin
      errors++; $display("FAIL reset_ufp: resp=%b rdata=%h want 0/0", ufp_resp, ufp_rdata);
    end
    checks++;
    if (dfp_read !== 1'b0 || dfp_write !== 1'b0 || dfp_addr !== 32'b0 || dfp_wdata !== 256'b0) begin
      errors++; $display("FAIL reset_dfp: rd=%b wr=%b addr=%h want all 0", dfp_read, dfp_write, dfp_addr);
    end
    checks++;
    if (perf_hits !== 32'b0 || perf_misses !== 32'b0 || perf_writebacks !== 32'b0) begin
      errors++; $display("FAIL reset_perf: %0d %0d %0d want 0 0 0", perf_hits, perf_misses, perf_writebacks);
    end
  endtask

  task automatic test_cold_read_miss();
    logic [255:0] l = init_line(27'h80);
    bit h, w; logic [31:0] va, rd, er; logic [255:0] vd;
    int n, lat, ra;
    l[63:32] = 32'hDEAD_BEEF;
    mem[27'h80] = l; arch[27'h80] = l;
    model_req(32'h1004, 4'hF, 4'h0, 32'h0, h, w, va, vd, er);
    do_req(32'h1004, 4'hF, 4'h0, 32'h0, 0, n, rd, lat, ra);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL cold_nresp: got %0d want 1", n); end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cold_rdata: got %h want deadbeef", rd); end
    checks++;
    if (log_q.size() != 1 || log_q[0].wr || log_q[0].addr !== 32'h1000) begin
      errors++; $display("FAIL cold_dfp: %0d txns want one read of 00001000", log_q.size());
    end
    checks++;
    if (ra !== 2) begin errors++; $display("FAIL cold_latency: resp %0d cycles after dfp_resp want 2", ra); end
  endtask

  task automatic test_write_read_hit();
    bit h, w; logic [31:0] va, rd, er; logic [255:0] vd;
    int n, lat, ra;
    model_req(32'h1004, 4'h0, 4'b0011, 32'h1234_5678, h, w, va, vd, er);
    do_req(32'h1004, 4'h0, 4'b0011, 32'h1234_5678, 0, n, rd, lat, ra);
    checks++;
    if (n !== 1 || lat !== 1 || rd !== 32'b0 || log_q.size() != 0) begin
      errors++; $display("FAIL write_hit: n=%0d lat=%0d rdata=%h txns=%0d want 1/1/0/0", n, lat, rd, log_q.size());
    end
    model_req(32'h1004, 4'hF, 4'h0, 32'h0, h, w, va, vd, er);
    do_req(32'h1004, 4'hF, 4'h0, 32'h0, 0, n, rd, lat, ra);
    checks++;
    if (rd !== 32'hDEAD_5678) begin errors++; $display("FAIL read_hit_data: got %h want dead5678", rd); end
    checks++;
    if (lat !== 1 || n !== 1 || log_q.size() != 0) begin
      errors++; $display("FAIL read_hit_timing: lat=%0d n=%0d txns=%0d want 1/1/0", lat, n, log_q.size());
    end
  endtask

  task automatic test_dirty_eviction();
    bit h, w; logic [31:0] va, rd, er; logic [255:0] vd;
    int n, lat, ra;
    model_req(32'h1204, 4'hF, 4'h0, 32'h0, h, w, va, vd, er);
    do_req(32'h1204, 4'hF, 4'h0, 32'h0, 0, n, rd, lat, ra);
    checks++;
    if (log_q.size() != 2 || !log_q[0].wr || log_q[0].addr !== 32'h1000 || log_q[0].data[63:32] !== 32'hDEAD_5678) begin
      errors++; $display("FAIL evict_writeback: %0d txns, want write of 00001000 with word1 dead5678", log_q.size());
    end
    checks++;
    if (log_q.size() != 2 || log_q[1].wr || log_q[1].addr !== 32'h1200) begin
      errors++; $display("FAIL evict_refill: %0d txns, want read of 00001200 second", log_q.size());
    end
    checks++;
    if (n !== 1 || rd !== er) begin errors++; $display("FAIL evict_resp: n=%0d rdata=%h want 1/%h", n, rd, er); end
  endtask

  task automatic test_both_masks();
    bit h, w; logic [31:0] va, rd, er; logic [255:0] vd;
    int n, lat, ra;
    model_req(32'h1200, 4'hF, 4'h1, 32'h0000_00AB, h, w, va, vd, er);
    do_req(32'h1200, 4'hF, 4'h1, 32'h0000_00AB, 0, n, rd, lat, ra);
    checks++;
    if (n !== 1 || lat !== 1 || rd !== 32'b0) begin
      errors++; $display("FAIL both_masks: n=%0d lat=%0d rdata=%h want 1/1/0", n, lat, rd);
    end
    model_req(32'h1000, 4'hF, 4'h0, 32'h0, h, w, va, vd, er);
    do_req(32'h1000, 4'hF, 4'h0, 32'h0, 0, n, rd, lat, ra);
    checks++;
    if (log_q.size() != 2 || !log_q[0].wr || log_q[0].addr !== 32'h1200 || log_q[0].data[7:0] !== 8'hAB) begin
      errors++; $display("FAIL both_masks_dirty: %0d txns, want writeback of 00001200 byte0 ab", log_q.size());
    end
    checks++;
    if (rd !== er) begin errors++; $display("FAIL refetch_after_wb: got %h want %h", rd, er); end
  endtask

  task automatic test_flush_alloc();
    bit h, w; logic [31:0] va, rd, er; logic [255:0] vd;
    int n, lat, ra;
    model_req(32'h2008, 4'hF, 4'h0, 32'h0, h, w, va, vd, er);
    do_req(32'h2008, 4'hF, 4'h0, 32'h0, 1, n, rd, lat, ra);
    checks++;
    if (n !== 0 || log_q.size() != 1 || log_q[0].addr !== 32'h2000) begin
      errors++; $display("FAIL flush_alloc: n=%0d txns=%0d want 0 resp and one refill", n, log_q.size());
    end
    model_req(32'h2008, 4'hF, 4'h0, 32'h0, h, w, va, vd, er);
    do_req(32'h2008, 4'hF, 4'h0, 32'h0, 0, n, rd, lat, ra);
    checks++;
    if (n !== 1 || lat !== 1 || log_q.size() != 0 || rd !== er) begin
      errors++; $display("FAIL flush_reissue: n=%0d lat=%0d txns=%0d rdata=%h want 1/1/0/%h", n, lat, log_q.size(), rd, er);
    end
  endtask

  task automatic test_flush_idle();
    int n = 0;
    @(negedge clk);
    ufp_addr = 32'h2008; ufp_rmask = 4'hF; ufp_wmask = 4'h0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; ufp_rmask = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (ufp_resp) n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL flush_idle: %0d resp want 0", n); end
  endtask

  task automatic test_back_to_back();
    bit h, w; logic [31:0] va, er; logic [255:0] vd;
    logic [5:0] bits = '0;
    int t0, n = 0;
    bit data_ok = 1;
    for (int k = 0; k < 3; k++) model_req(32'h2008, 4'hF, 4'h0, 32'h0, h, w, va, vd, er);
    @(negedge clk);
    ufp_addr = 32'h2008; ufp_rmask = 4'hF; ufp_wmask = 4'h0;
    t0 = cyc;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ufp_resp) begin
        n++; bits[cyc - t0 - 1] = 1'b1;
        if (ufp_rdata !== er) data_ok = 0;
      end
    end
    ufp_rmask = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (n !== 3 || bits !== 6'b010101) begin
      errors++; $display("FAIL back_to_back: n=%0d pattern=%b want 3/010101", n, bits);
    end
    checks++;
    if (!data_ok) begin errors++; $display("FAIL back_to_back_data: want %h each resp", er); end
  endtask

  task automatic test_random();
    bit h, w; logic [31:0] a, va, rd, er, wd; logic [255:0] vd;
    logic [3:0] rm, wm;
    int n, lat, ra, kind, exp_txn;
    for (int t = 0; t < 150; t++) begin
      a = (32'($urandom_range(8, 11)) << 9) | (32'($urandom_range(0, 3)) << 5) | 32'($urandom_range(0, 31));
      kind = $urandom_range(0, 2);
      rm = (kind == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      wm = (kind == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      wd = $urandom;
      model_req(a, rm, wm, wd, h, w, va, vd, er);
      do_req(a, rm, wm, wd, 0, n, rd, lat, ra);
      exp_txn = h ? 0 : (w ? 2 : 1);
      checks++;
      if (n !== 1 || rd !== er) begin
        errors++; $display("FAIL rand_resp[%0d]: a=%h n=%0d rdata=%h want 1/%h", t, a, n, rd, er);
      end
      checks++;
      if (log_q.size() != exp_txn) begin
        errors++; $display("FAIL rand_txns[%0d]: a=%h got %0d want %0d", t, a, log_q.size(), exp_txn);
      end else if (w && (!log_q[0].wr || log_q[0].addr !== va || log_q[0].data !== vd)) begin
        errors++; $display("FAIL rand_wb[%0d]: addr=%h want %h", t, log_q[0].addr, va);
      end else if (!h && (log_q[exp_txn-1].wr || log_q[exp_txn-1].addr !== {a[31:5], 5'b0})) begin
        errors++; $display("FAIL rand_refill[%0d]: addr=%h want %h", t, log_q[exp_txn-1].addr, {a[31:5], 5'b0});
      end
      checks++;
      if (h ? (lat !== 1) : (ra !== 2)) begin
        errors++; $display("FAIL rand_latency[%0d]: hit=%0b lat=%0d after_dfp=%0d", t, h, lat, ra);
      end
    end
  endtask

  task automatic test_perf();
    checks++;
`ifdef DCACHE_PERF_CNT_EN
    if (perf_hits !== 32'(mh) || perf_misses !== 32'(mm) || perf_writebacks !== 32'(mw)) begin
      errors++; $display("FAIL perf: %0d %0d %0d want %0d %0d %0d", perf_hits, perf_misses, perf_writebacks, mh, mm, mw);
    end
`else
    if (perf_hits !== 32'b0 || perf_misses !== 32'b0 || perf_writebacks !== 32'b0) begin
      errors++; $display("FAIL perf_tied: %0d %0d %0d want 0 0 0", perf_hits, perf_misses, perf_writebacks);
    end
`endif
  endtask

  task automatic test_reset_in_writeback();
    bit h, w; logic [31:0] va, rd, er; logic [255:0] vd;
    int n, lat, ra;
    bit seen = 0;
    model_req(32'h3000, 4'h0, 4'hF, 32'hCAFE_F00D, h, w, va, vd, er);
    do_req(32'h3000, 4'h0, 4'hF, 32'hCAFE_F00D, 0, n, rd, lat, ra);
    mem_hold = 1;
    @(negedge clk);
    ufp_addr = 32'h5000; ufp_rmask = 4'hF; ufp_wmask = 4'h0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (dfp_write) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL reset_wb_setup: dfp_write=0 want 1 within 50 cycles"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dfp_write !== 1'b0 || dfp_read !== 1'b0) begin
      errors++; $display("FAIL reset_async_drop: wr=%b rd=%b want 0/0", dfp_write, dfp_read);
    end
    ufp_rmask = 4'h0;
    @(negedge clk);
    rst_n = 1'b1; mem_hold = 0;
    for (int s = 0; s < NUM_SETS; s++) begin mvalid[s] = 0; mdirty[s] = 0; end
    arch = mem; mh = 0; mm = 0; mw = 0;
    model_req(32'h3000, 4'hF, 4'h0, 32'h0, h, w, va, vd, er);
    do_req(32'h3000, 4'hF, 4'h0, 32'h0, 0, n, rd, lat, ra);
    checks++;
    if (n !== 1 || log_q.size() != 1 || log_q[0].wr || rd !== er) begin
      errors++; $display("FAIL reset_then_miss: n=%0d txns=%0d rdata=%h want 1/1 read/%h", n, log_q.size(), rd, er);
    end
  endtask

  task automatic test_dfp_protocol();
    checks++;
    if (proto_bad !== 0) begin errors++; $display("FAIL dfp_protocol: %0d violations want 0", proto_bad); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    ufp_addr = '0; ufp_rmask = '0; ufp_wmask = '0; ufp_wdata = '0;
    for (int s = 0; s < NUM_SETS; s++) begin mvalid[s] = 0; mdirty[s] = 0; mtag[s] = '0; end
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_cold_read_miss();
    test_write_read_hit();
    test_dirty_eviction();
    test_both_masks();
    test_flush_alloc();
    test_flush_idle();
    test_back_to_back();
    test_random();
    test_perf();
    test_reset_in_writeback();
    test_dfp_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Blocking, direct-mapped, write-back, write-allocate data cache.
- Responds to the LSQ's D-cache request interface (addr/rmask/wmask/wdata in; rdata/resp out) and refills from memory over a single-beat 256-bit line interface.
- Sits between the load/store queue arbiter and the memory/adapter.
- Serves one request at a time; the requester holds its signals stable until `ufp_resp`.

Parameters:
- NUM_SETS, 16, number of cache lines (power of 2, ≥2). Line size is fixed at 32 bytes. Tag width = 27 − log2(NUM_SETS).

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; abandons the response of the in-flight request
- ufp_addr  in  32  byte address; [1:0] ignored, [4:2] word select
- ufp_rmask  in  4  read byte mask; nonzero = read request
- ufp_wmask  in  4  write byte mask; nonzero = write request
- ufp_wdata  in  32  write data, byte lanes per wmask
- ufp_rdata  out  32  full read word, valid while ufp_resp
- ufp_resp  out  1  one-cycle completion pulse
- dfp_addr  out  32  line-aligned memory address ([4:0]=0)
- dfp_read  out  1  line read request, held until dfp_resp
- dfp_write  out  1  line write request, held until dfp_resp
- dfp_wdata  out  256  victim line data
- dfp_rdata  in  256  refill line data, valid with dfp_resp
- dfp_resp  in  1  memory completion pulse
- perf_hits, perf_misses, perf_writebacks  out  32 each  event counters (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - FSM → IDLE; all valid and dirty bits cleared.
  - All outputs 0; counters 0.
  - Tag and data array contents are don't-care.
- Request detection: in IDLE, a request is present when `(ufp_rmask|ufp_wmask)!=0` and flush=0.
  - On detection, latch addr, rmask, wmask and wdata, plus a write flag = `(wmask!=0)`.
  - wmask wins if both masks are nonzero.
  - Go to COMPARE.
- COMPARE (hit = valid[set] && tag[set]==addr tag):
  - Read hit: ufp_rdata = word[addr[4:2]]; ufp_resp=1; → IDLE.
  - Write hit: merge wdata bytes per wmask into the word; set dirty; ufp_rdata=0; ufp_resp=1; → IDLE.
  - Miss, valid && dirty: → WRITEBACK.
  - Miss, otherwise: → ALLOCATE.
- WRITEBACK:
  - dfp_write=1; dfp_addr = {old tag, set, 5'b0}; dfp_wdata = victim line.
  - On dfp_resp: clear dirty; → ALLOCATE.
- ALLOCATE:
  - dfp_read=1; dfp_addr = {addr[31:5], 5'b0}.
  - On dfp_resp: write line = dfp_rdata, tag, valid=1, dirty=0; → COMPARE (which then hits).
- Latency:
  - Hit: request seen in cycle N, ufp_resp in cycle N+1.
  - Clean miss: ufp_resp 2 cycles after dfp_resp.
  - Dirty miss: adds one full write transaction.
- ufp_resp is exactly one cycle per accepted request; never asserted in IDLE/WRITEBACK/ALLOCATE.
- After ufp_resp the FSM is in IDLE next cycle. A held or new request is sampled then, so back-to-back hits give one resp every 2 cycles.
- dfp_read and dfp_write are never both high. dfp_addr/dfp_wdata stay stable while a request is high. A request drops the cycle after dfp_resp.
- Flush (sets a drop flag cleared on return to IDLE):
  - In IDLE: the request that cycle is ignored.
  - In any other state: the memory transaction in progress completes normally; array updates still happen, including a latched write's merge (committed stores are never lost).
  - ufp_resp for that request is suppressed.
  - A new request is not accepted until IDLE.
- Reset mid-transaction: immediate return to IDLE; dfp_read/dfp_write drop asynchronously.
- Tag compare covers all tag bits; set index = addr[4+log2(NUM_SETS):5].

Optional Feature:
- Macro: DCACHE_PERF_CNT_EN.
- Defined:
  - perf_hits increments on each COMPARE hit that was not preceded by ALLOCATE for the same request.
  - perf_misses increments on each COMPARE miss.
  - perf_writebacks increments on each WRITEBACK dfp_resp.
  - All counters saturate at 32'hFFFF_FFFF; flush does not stop counting.
- Undefined: counter logic absent; the three ports are tied to 0.

Test Plan:
- Cold read miss: reset, read addr 0x0000_1004 rmask 4'hF, memory returns line with word1=0xDEAD_BEEF → dfp_read with dfp_addr 0x0000_1000; ufp_resp once with ufp_rdata 0xDEAD_BEEF, 2 cycles after dfp_resp.
- Write hit then read hit: write 0x0000_1004 wmask 4'b0011 wdata 0x1234_5678, then read same → write resp 1 cycle after request, no dfp traffic; read returns 0xDEAD_5678.
- Dirty eviction, NUM_SETS=16: after the previous test, read 0x0000_1204 (same set, different tag) → dfp_write to 0x0000_1000 with line word1 = 0xDEAD_5678, then dfp_read to 0x0000_1200; exactly one ufp_resp.
- Both masks: rmask 4'hF, wmask 4'h1 on a hit → treated as write; ufp_rdata 0; dirty set.
- Flush during ALLOCATE of a read: refill completes and the line becomes valid; no ufp_resp; a re-issued read hits with 1-cycle latency.
- Async reset asserted during WRITEBACK → dfp_write drops without waiting for a clock edge; the next read to the same line misses.
